// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and decode helpers for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MA_IDLE = 2'd0;
  localparam logic [1:0] MA_REQ  = 2'd1;
  localparam logic [1:0] MA_WAIT = 2'd2;
  localparam logic [1:0] MA_DONE = 2'd3;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Unsigned byte/half encodings exist only for loads; stores fall back to word.
  function automatic size_e decode_size(input logic is_write, input logic [2:0] f3);
    size_e sz;
    sz = SZ_W;
    if (f3 == F3_B || (!is_write && f3 == F3_BU)) begin
      sz = SZ_B;
    end else if (f3 == F3_H || (!is_write && f3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

  function automatic logic is_aligned(input size_e sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input size_e sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_wdata(input size_e sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h000000, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0000, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: request latch, gnt/rvalid handshake to data memory,
// pipeline stall generation and aligned/extended load result.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;

  size_e       req_size;
  logic        req_aligned;
  logic        accept;
  logic [31:0] ld_data;

  assign req_size    = decode_size(req_write, req_funct3);
  assign req_aligned = is_aligned(req_size, req_addr[1:0]);
  assign accept      = (state_q == MA_IDLE) && req_valid && req_aligned;

  // Alignment uses the latched offset/funct3 since req_* may move after DONE.
  mem_load_align u_align (
    .word_i   (mem_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
    case (state_q)
      MA_IDLE: begin
        if (accept) begin
          state_d     = MA_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = req_write;
          mem_be_d    = byte_enables(req_size, req_addr[1:0]);
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = replicate_wdata(req_size, req_wdata);
          off_d       = req_addr[1:0];
          f3_d        = req_funct3;
        end
      end
      MA_REQ: begin
        // rvalid is deliberately not looked at until the grant has been seen.
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = mem_we_q ? MA_DONE : MA_WAIT;
        end
      end
      MA_WAIT: begin
        if (mem_rvalid) begin
          rsp_rdata_d = ld_data;
          state_d     = MA_DONE;
        end
      end
      MA_DONE: state_d = MA_IDLE;
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= MA_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      rsp_rdata_q <= 32'h0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
    end
  end

  assign stall     = accept || (state_q == MA_REQ) || (state_q == MA_WAIT);
  assign misalign  = (state_q == MA_IDLE) && req_valid && !req_aligned;
  assign rsp_valid = (state_q == MA_DONE);
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset-mid-access sequence and
// randomized accesses checked against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, misalign, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;      // cycles of REQ before gnt
    int          rd;      // rvalid comes this many cycles after gnt
    logic        mis;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] lrdata;
    int          nstall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Access width in bytes straight from the funct3 tables.
  function automatic int m_size(input logic wr, input logic [2:0] f3);
    if (f3 == 3'b000 || (!wr && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!wr && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic vec_t m_build(input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input int gd, input int rd);
    vec_t        v;
    int          sz, off;
    logic [31:0] mask, val;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gd = gd; v.rd = rd;
    sz     = m_size(wr, f3);
    off    = int'(addr % 4);
    v.mis  = (addr % sz) != 0;
    v.be   = 4'(((1 << sz) - 1) << off);
    v.maddr = addr - 32'(off);
    if (sz == 1)      v.mwdata = (wdata & 32'hFF) * 32'h01010101;
    else if (sz == 2) v.mwdata = (wdata & 32'hFFFF) * 32'h00010001;
    else              v.mwdata = wdata;
    mask = 32'((64'h1 << (8 * sz)) - 64'h1);
    val  = (rdata >> (8 * off)) & mask;
    if (sz < 4 && !f3[2] && val[8*sz-1]) val = val | ~mask;
    v.lrdata = val;
    v.nstall = wr ? 2 + gd : 2 + gd + rd;
    return v;
  endfunction

  // Starts and ends on a falling clock edge; acts as the memory responder.
  task automatic run_txn(input vec_t v);
    int          stalls  = 0;
    int          gcnt    = 0;
    int          wcnt    = 0;
    bit          granted = 0;
    bit          done    = 0;
    logic [31:0] exp_rd;
    exp_rd     = v.wr ? last_rd : v.lrdata;
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    #1;
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("misalign", 32'(misalign), 32'(v.mis));
    if (v.mis) begin
      chk("mis_stall", 32'(stall), 32'd0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        chk("mis_mem_req", 32'(mem_req), 32'd0);
        chk("mis_stall_hold", 32'(stall), 32'd0);
      end
      req_valid = 1'b0;
      @(negedge clk);
      return;
    end
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
      if (!stall) begin
        done = 1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("stall_cycles", 32'(stalls), 32'(v.nstall));
        break;
      end
      stalls++;
      if (c > 0) chk("rsp_valid_low", 32'(rsp_valid), 32'd0);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (mem_req) begin
        chk("mem_we", 32'(mem_we), 32'(v.wr));
        chk("mem_be", 32'(mem_be), 32'(v.be));
        chk("mem_addr", mem_addr, v.maddr);
        if (v.wr) chk("mem_wdata", mem_wdata, v.mwdata);
        mem_gnt    = (gcnt == v.gd);
        mem_rvalid = 1'($urandom_range(0, 1));
        if (mem_gnt) granted = 1;
        gcnt++;
      end else if (granted && !v.wr) begin
        wcnt++;
        mem_rvalid = (wcnt == v.rd);
        if (mem_rvalid) mem_rdata = v.rdata;
      end
    end
    chk("completed", 32'(done), 32'd1);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!v.wr) last_rd = v.lrdata;
    @(negedge clk);
  endtask

  initial begin
    vec_t        tbl [15];
    vec_t        v;
    logic [31:0] a;

    tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,      0, 1, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0,      2};
    tbl[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,      0, 1, 1'b0, 4'h8, 32'h100, 32'hA5A5A5A5, 32'h0,      2};
    tbl[2]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'h12F03456, 0, 1, 1'b0, 4'h4, 32'h100, 32'h0, 32'hFFFFFFF0, 3};
    tbl[3]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h12F03456, 0, 1, 1'b0, 4'h4, 32'h100, 32'h0, 32'h000000F0, 3};
    tbl[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h12F03456, 0, 1, 1'b0, 4'hC, 32'h100, 32'h0, 32'h000012F0, 3};
    tbl[5]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 2, 3, 1'b0, 4'hF, 32'h104, 32'h0, 32'hCAFEF00D, 7};
    tbl[6]  = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h0,      0, 1, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0,      0};
    tbl[7]  = '{1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,      1, 1, 1'b0, 4'hC, 32'h100, 32'hBEEFBEEF, 32'h0,      3};
    tbl[8]  = '{1'b0, 3'b101, 32'h200, 32'h0,        32'h12348001, 0, 2, 1'b0, 4'h3, 32'h200, 32'h0, 32'h00008001, 4};
    tbl[9]  = '{1'b0, 3'b001, 32'h200, 32'h0,        32'h12348001, 0, 1, 1'b0, 4'h3, 32'h200, 32'h0, 32'hFFFF8001, 3};
    tbl[10] = '{1'b1, 3'b111, 32'h20C, 32'h01234567, 32'h0,      0, 1, 1'b0, 4'hF, 32'h20C, 32'h01234567, 32'h0,      2};
    tbl[11] = '{1'b0, 3'b011, 32'h300, 32'h0,        32'h89ABCDEF, 1, 1, 1'b0, 4'hF, 32'h300, 32'h0, 32'h89ABCDEF, 4};
    tbl[12] = '{1'b1, 3'b001, 32'h103, 32'h0000FFFF, 32'h0,      0, 1, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0,      0};
    tbl[13] = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 1, 1'b0, 4'h2, 32'h100, 32'h0, 32'h0000007F, 3};
    tbl[14] = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 0, 1, 1'b0, 4'h8, 32'h100, 32'h0, 32'h00000080, 3};

    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_txn(tbl[i]);

    // Reset while a load sits in WAIT, then a store must complete normally.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h55AA55AA;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); #1;
    chk("rw_req_phase", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk); #1;
    mem_gnt = 1'b0;
    chk("rw_wait_stall", 32'(stall), 32'd1);
    chk("rw_wait_req", 32'(mem_req), 32'd0);
    rstn = 1'b0; req_valid = 1'b0;
    #1;
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_misalign", 32'(misalign), 32'd0);
    chk("rw_mem_req", 32'(mem_req), 32'd0);
    chk("rw_mem_we", 32'(mem_we), 32'd0);
    chk("rw_mem_be", 32'(mem_be), 32'd0);
    chk("rw_mem_addr", mem_addr, 32'h0);
    chk("rw_mem_wdata", mem_wdata, 32'h0);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
    run_txn(m_build(1'b1, 3'b010, 32'h40, 32'h13579BDF, 32'h0, 1, 1));

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      v = m_build(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      run_txn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
